// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: hazard stalls,
// memory-wait freeze, branch redirects, halt drain and stall/flush counters.
module hazard_ctrl #(
    parameter int HALT_DRAIN_CYCLES = 3,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic             is_branch_ID,
    input  logic             takeBranch,
    input  logic             halt_ID,
    input  logic [4:0]       rd_IDEX,
    input  logic             regWrite_IDEX,
    input  logic             memRead_IDEX,
    input  logic [4:0]       rd_EXMEM,
    input  logic             memRead_EXMEM,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             pipe_write,
    output logic             MEMWB_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DC_W = (HALT_DRAIN_CYCLES < 2) ? 1 : $clog2(HALT_DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic freeze;
    logic hz_rs1;
    logic hz_rs2;
    logic id_stall;

    // An ALU producer only matters to a branch, which compares operands in ID;
    // a load matters to everything one cycle later, and to a branch two.
    function automatic logic hz(input logic [4:0] r);
        return (r != 5'd0) &&
               ((regWrite_IDEX && (rd_IDEX == r) && (memRead_IDEX || is_branch_ID)) ||
                (is_branch_ID && memRead_EXMEM && (rd_EXMEM == r)));
    endfunction

    assign freeze   = dmem_req & ~dmem_ready;
    assign hz_rs1   = hz(rs1_ID);
    assign hz_rs2   = hz(rs2_ID);
    assign id_stall = (uses_rs1_ID & hz_rs1) | (uses_rs2_ID & hz_rs2);

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the branches below can infer a latch.
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        pc_write       = 1'b1;
        pc_sel_branch  = 1'b0;
        IFID_write     = 1'b1;
        IFID_flush     = 1'b0;
        IDEX_bubble    = 1'b0;
        pipe_write     = 1'b1;
        MEMWB_bubble   = 1'b0;
        halted         = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            IFID_write   = 1'b0;
            pipe_write   = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_bubble  = 1'b1;
            MEMWB_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (freeze) begin
                        pc_write     = 1'b0;
                        IFID_write   = 1'b0;
                        pipe_write   = 1'b0;
                        MEMWB_bubble = 1'b1;
                    end else if (id_stall) begin
                        pc_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else if (halt_ID) begin
                        pc_write    = 1'b0;
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                        state_d     = DRAIN;
                        drain_cnt_d = DC_W'(HALT_DRAIN_CYCLES);
                    end else if (takeBranch) begin
                        pc_sel_branch = 1'b1;
                        IFID_flush    = 1'b1;
                        if (flush_count_q != {CNT_W{1'b1}})
                            flush_count_d = flush_count_q + CNT_W'(1);
                    end else if (!imem_ready) begin
                        pc_write   = 1'b0;
                        IFID_flush = 1'b1;
                    end
                    // A redirect always writes the PC, so pc_write low implies no taken branch.
                    if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}}))
                        stall_cycles_d = stall_cycles_q + CNT_W'(1);
                end
                DRAIN: begin
                    pc_write    = 1'b0;
                    IFID_flush  = 1'b1;
                    IDEX_bubble = 1'b1;
                    if (freeze) begin
                        IFID_write   = 1'b0;
                        pipe_write   = 1'b0;
                        MEMWB_bubble = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DC_W'(1);
                        if (drain_cnt_q == DC_W'(1))
                            state_d = HALTED;
                    end
                end
                HALTED: begin
                    pc_write     = 1'b0;
                    IFID_write   = 1'b0;
                    pipe_write   = 1'b0;
                    IFID_flush   = 1'b1;
                    IDEX_bubble  = 1'b1;
                    MEMWB_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            drain_cnt_q    <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It observes the decode stage (register sources, branch resolution, halt) and the downstream pipeline registers, and drives the PC and IF/ID, ID/EX, EX/MEM and MEM/WB enables, flushes and bubbles. It resolves load-use and branch-operand hazards, freezes the pipeline on data-memory wait, sequences the halt drain, and keeps stall and flush counters.

## Interface
- HALT_DRAIN_CYCLES, 3: cycles allowed after HALT leaves ID for older instructions to retire.
- CNT_W, 16: width of the performance counters.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rs1_ID, rs2_ID  in  5  source register fields of the instruction in ID
- uses_rs1_ID, uses_rs2_ID  in  1  instruction in ID reads rs1 / rs2
- is_branch_ID  in  1  instruction in ID is a branch or JALR, with operands compared in ID
- takeBranch  in  1  branch unit requests a redirect
- halt_ID  in  1  HALT decoded in ID
- rd_IDEX  in  5  destination register in ID/EX
- regWrite_IDEX  in  1  write-enable in ID/EX
- memRead_IDEX  in  1  load in ID/EX
- rd_EXMEM  in  5  destination register in EX/MEM
- memRead_EXMEM  in  1  load in EX/MEM
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  load or store active in MEM
- dmem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC register enable
- pc_sel_branch  out  1  PC loads branch_PC, not PC+4
- IFID_write  out  1  IF/ID enable
- IFID_flush  out  1  IF/ID loads NOP
- IDEX_bubble  out  1  ID/EX loads NOP; controls cleared
- pipe_write  out  1  ID/EX and EX/MEM enable
- MEMWB_bubble  out  1  MEM/WB loads NOP
- halted  out  1  core stopped
- stall_cycles  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of taken redirects

## Operation
- State machine:
  - RUN
  - DRAIN, which uses a down-counter drain_cnt
  - HALTED
- Outputs are combinational from the state and the inputs; the state and counters are registered.
- Defaults, which also apply when no condition below matches: pc_write=1, IFID_write=1, pipe_write=1. All other outputs are 0.
- freeze = dmem_req & ~dmem_ready.
- hz(r) is true when both of the following hold:
  - r != 0
  - either (a) regWrite_IDEX & rd_IDEX==r & (memRead_IDEX | is_branch_ID), or (b) is_branch_ID & memRead_EXMEM & rd_EXMEM==r
- id_stall = (uses_rs1_ID & hz(rs1_ID)) | (uses_rs2_ID & hz(rs2_ID)).
- In RUN, the first matching condition wins:
  1. freeze: pc_write=0, IFID_write=0, pipe_write=0, MEMWB_bubble=1. takeBranch and halt_ID are ignored.
  2. id_stall: pc_write=0, IFID_write=0, IDEX_bubble=1. takeBranch and halt_ID are ignored because the operands are stale.
  3. halt_ID: pc_write=0, IFID_flush=1, IDEX_bubble=1. Next state is DRAIN with drain_cnt=HALT_DRAIN_CYCLES.
  4. takeBranch: pc_sel_branch=1, IFID_flush=1. flush_count increments.
  5. ~imem_ready: pc_write=0, IFID_flush=1.
- In DRAIN:
  - Every cycle: pc_write=0, IFID_flush=1, IDEX_bubble=1.
  - When freeze is also true, priority 1 applies as well and drain_cnt holds.
  - Otherwise drain_cnt decrements.
  - When drain_cnt==1 and there is no freeze, the next state is HALTED.
- In HALTED: pc_write=0, IFID_write=0, pipe_write=0, IFID_flush=1, IDEX_bubble=1, MEMWB_bubble=1, halted=1. Every input is ignored, and the only exit is rst.
- stall_cycles increments in RUN on every cycle with pc_write=0 and no takeBranch. This covers freeze, id_stall, halt and imem wait. It saturates at 2^CNT_W-1.
- flush_count saturates in the same way.

## Timing
- While rst is high, asynchronously: state=RUN, drain_cnt=0, counters=0, halted=0, pc_write=0, IFID_write=0, pipe_write=0, IFID_flush=1, IDEX_bubble=1, MEMWB_bubble=1, pc_sel_branch=0.
- On the first clock after rst falls, the default outputs apply.
- Zero-cycle latency: every output reflects its inputs in the same cycle.
- A load-use stall lasts 1 cycle.
- A branch that depends on an ALU result stalls 1 cycle.
- A branch that depends on a load stalls 2 cycles: the load in EX, then the load in MEM.
- A freeze lasts exactly as long as dmem_req & ~dmem_ready. The cycle in which dmem_ready rises advances normally.
- With no freeze, halted rises HALT_DRAIN_CYCLES+1 cycles after the cycle in which halt_ID is accepted.
- rst asserted mid-DRAIN or in HALTED returns the block to RUN immediately.

## Test plan
- Load-use: memRead_IDEX=1, regWrite_IDEX=1, rd_IDEX=5; ID has uses_rs1_ID=1, rs1_ID=5.
  - Expect 1 cycle with pc_write=0, IFID_write=0, IDEX_bubble=1, then defaults. stall_cycles=1.
  - Repeat with rd_IDEX=0: expect no stall.
- Branch on load: is_branch_ID=1, rs2_ID=7; a load to x7 in ID/EX, then in EX/MEM.
  - Expect 2 stall cycles with takeBranch=1 held and pc_sel_branch=0.
  - On the 3rd cycle: pc_sel_branch=1, IFID_flush=1, flush_count=1.
- Freeze priority: dmem_req=1 with dmem_ready=0 for 3 cycles, while id_stall and takeBranch are also asserted.
  - Expect 3 cycles with pipe_write=0 and MEMWB_bubble=1, and pc_sel_branch=0.
  - In cycle 4, id_stall behaviour applies.
- imem wait with a redirect: imem_ready=0 and takeBranch=1 together.
  - Expect pc_write=1, pc_sel_branch=1, IFID_flush=1.
  - With imem_ready=0 alone, expect pc_write=0, IFID_flush=1.
- Halt: halt_ID=1, with a 1-cycle freeze during DRAIN.
  - Expect 4 DRAIN cycles, then halted=1 with all writes 0.
  - takeBranch=1 in HALTED: expect no effect.
- Reset: assert rst asynchronously mid-DRAIN, between clock edges.
  - Expect all outputs at their reset values immediately, and counters at 0.
  - After release, the block is in RUN with default outputs.
  - A counter preloaded near 2^CNT_W-1 saturates and does not wrap.
